// File: rtl/cmp_config_pkg.sv
// -----------------------------------------------------------------------------
// cmp_config_pkg
// Shared definitions for the CMP_CONFIG packet receiver:
//   - parser state encoding
//   - readout word map (iteration count in word 0, salt from word 1 upward)
//   - subtype_index(): looks up a subtype character in a packed ASCII list
// -----------------------------------------------------------------------------
package cmp_config_pkg;

    typedef enum logic [3:0] {
        ST_SALT,
        ST_SUBTYPE,
        ST_ITER,
        ST_HCNT0,
        ST_HCNT1,
        ST_CMP_DATA,
        ST_WAIT_APPLIED,
        ST_MAGIC,
        ST_ERROR
    } state_t;

    localparam int ITER_WORD  = 0;
    localparam int SALT_WORD0 = 1;

    typedef struct packed {
        logic       valid;
        logic [1:0] index;
    } subtype_match_t;

    // Characters are packed MSB first: index 0 lives in bits 31:24. A zero
    // byte marks an unused slot and never matches. The lowest index wins if
    // the same character appears twice.
    function automatic subtype_match_t subtype_index(input logic [7:0]  b,
                                                     input logic [31:0] subtypes);
        subtype_match_t m;
        logic [7:0]     c;
        m = '0;
        for (int i = 3; i >= 0; i--) begin
            c = subtypes[8*(3-i) +: 8];
            if (c != 8'h00 && c == b) begin
                m.valid = 1'b1;
                m.index = 2'(i);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/cmp_config_ram.sv
// -----------------------------------------------------------------------------
// cmp_config_ram
// Small distributed RAM holding the readout words (iteration count + salt).
// Ports:
//   CLK    in   clock
//   we     in   write enable (synchronous write)
//   waddr  in   write word address
//   wdata  in   write data
//   raddr  in   read word address (asynchronous read)
//   rdata  out  read data; addresses at or above WORDS read as 0
// -----------------------------------------------------------------------------
module cmp_config_ram #(
    parameter int WORDS = 5,
    parameter int AW    = 3
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // NOTE: the storage array has no reset so it maps onto LUT RAM; its
    // contents are meaningless until the first packet has written them.
    always_ff @(posedge CLK) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = (int'(raddr) < WORDS) ? mem[raddr] : 32'd0;

endmodule

// File: rtl/cmp_config_rx.sv
// -----------------------------------------------------------------------------
// cmp_config_rx
// CMP_CONFIG packet receiver. Parses salt, subtype, iteration count, hash
// count, comparator bytes and a magic trailer from a byte stream; stores salt
// and iteration count in a readout RAM; streams comparator bytes out; and
// holds off input until the core acknowledges the new configuration.
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   din, wr_en          input byte stream (ignored while full)
//   full                back-pressure
//   error, error_clr    sticky protocol error and its clear pulse
//   mode_cmp            1 = comparator data expected, 0 = hash count must be 0
//   new_cmp_config      configuration parsed, waiting for cmp_config_applied
//   cmp_config_applied  acknowledge from the core
//   hash_count          number of hashes in the last accepted packet
//   cmp_wr_addr/en/din  registered comparator byte write port
//   addr, dout          readout port (word 0 = iteration count, 1.. = salt)
//   subtype             index of the accepted subtype, latched on ack
// -----------------------------------------------------------------------------
module cmp_config_rx
    import cmp_config_pkg::*;
#(
    parameter int          SALT_BYTES     = 16,
    parameter int          ITER_BYTES     = 4,
    parameter int          SETTING_MAX    = 31,
    parameter int          NUM_HASHES     = 512,
    parameter int          CMP_WORD_BYTES = 4,
    parameter logic [7:0]  MAGIC          = 8'hCC,
    parameter logic [31:0] SUBTYPES       = "abxy",
    localparam int HCW = $clog2(NUM_HASHES + 1),
    localparam int CAW = $clog2(NUM_HASHES * CMP_WORD_BYTES),
    localparam int AW  = $clog2(1 + SALT_BYTES / 4)
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [7:0]     din,
    input  logic           wr_en,
    output logic           full,
    output logic           error,
    input  logic           error_clr,
    input  logic           mode_cmp,
    output logic           new_cmp_config,
    input  logic           cmp_config_applied,
    output logic [HCW-1:0] hash_count,
    output logic [CAW-1:0] cmp_wr_addr,
    output logic           cmp_wr_en,
    output logic [7:0]     cmp_din,
    input  logic [AW-1:0]  addr,
    output logic [31:0]    dout,
    output logic [1:0]     subtype
);

    localparam int WORDS    = 1 + SALT_BYTES / 4;
    localparam int BCW      = $clog2(SALT_BYTES);
    localparam int HI_SHIFT = SETTING_MAX + 1;

    state_t         state;
    logic [BCW-1:0] byte_cnt;
    logic [23:0]    salt_shift;   // last three salt bytes, oldest in 7:0
    logic [31:0]    iter_reg;
    logic [7:0]     cnt_lo;
    logic [1:0]     pending_sub;

    logic           ram_we;
    logic [AW-1:0]  ram_waddr;
    logic [31:0]    ram_wdata;

    logic           accept;
    subtype_match_t sub_match;
    logic [31:0]    iter_next;
    logic [15:0]    cnt_full;
    logic           iter_too_big;
    logic           cnt_bad;
    logic [AW-1:0]  salt_word;
    logic [CAW-1:0] next_addr;
    logic [CAW-1:0] last_addr;

    assign accept    = wr_en & ~full;
    assign sub_match = subtype_index(din, SUBTYPES);
    assign salt_word = AW'(byte_cnt >> 2) + AW'(SALT_WORD0);
    assign cnt_full  = {din, cnt_lo};

    assign iter_too_big = (iter_reg >> HI_SHIFT) != 32'd0;
    assign cnt_bad = (cnt_full > 16'(NUM_HASHES)) || iter_too_big ||
                     (mode_cmp ? (cnt_full == 16'd0) : (cnt_full != 16'd0));

    // cmp_wr_addr idles at all-ones so the first increment lands on 0.
    assign next_addr = cmp_wr_addr + CAW'(1);
    assign last_addr = CAW'(32'(hash_count) * 32'(CMP_WORD_BYTES) - 32'd1);

    // NOTE: combinational blocks assign every output a default first so no
    // path leaves a value held, which would infer a latch.
    always_comb begin
        iter_next = iter_reg;
        iter_next[8*byte_cnt[1:0] +: 8] = din;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state          <= ST_SALT;
            byte_cnt       <= '0;
            salt_shift     <= '0;
            iter_reg       <= '0;
            cnt_lo         <= '0;
            pending_sub    <= '0;
            subtype        <= '0;
            hash_count     <= '0;
            cmp_wr_addr    <= '1;
            cmp_wr_en      <= 1'b0;
            cmp_din        <= '0;
            full           <= 1'b0;
            error          <= 1'b0;
            new_cmp_config <= 1'b0;
            ram_we         <= 1'b0;
            ram_waddr      <= '0;
            ram_wdata      <= '0;
        end else begin
            ram_we    <= 1'b0;
            cmp_wr_en <= 1'b0;
            unique case (state)
                ST_SALT: if (accept) begin
                    salt_shift <= {din, salt_shift[23:8]};
                    if (byte_cnt[1:0] == 2'd3) begin
                        ram_we    <= 1'b1;
                        ram_waddr <= salt_word;
                        ram_wdata <= {din, salt_shift};
                    end
                    if (byte_cnt == BCW'(SALT_BYTES - 1)) begin
                        byte_cnt <= '0;
                        state    <= ST_SUBTYPE;
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                ST_SUBTYPE: if (accept) begin
                    if (sub_match.valid) begin
                        pending_sub <= sub_match.index;
                        iter_reg    <= '0;
                        state       <= ST_ITER;
                    end else begin
                        error <= 1'b1;
                        full  <= 1'b1;
                        state <= ST_ERROR;
                    end
                end
                ST_ITER: if (accept) begin
                    iter_reg <= iter_next;
                    if (byte_cnt == BCW'(ITER_BYTES - 1)) begin
                        ram_we    <= 1'b1;
                        ram_waddr <= AW'(ITER_WORD);
                        ram_wdata <= iter_next;
                        byte_cnt  <= '0;
                        state     <= ST_HCNT0;
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                ST_HCNT0: if (accept) begin
                    cnt_lo <= din;
                    state  <= ST_HCNT1;
                end
                ST_HCNT1: if (accept) begin
                    if (cnt_bad) begin
                        error <= 1'b1;
                        full  <= 1'b1;
                        state <= ST_ERROR;
                    end else begin
                        hash_count <= HCW'(cnt_full);
                        if (mode_cmp) begin
                            cmp_wr_addr <= '1;
                            state       <= ST_CMP_DATA;
                        end else begin
                            new_cmp_config <= 1'b1;
                            full           <= 1'b1;
                            state          <= ST_WAIT_APPLIED;
                        end
                    end
                end
                ST_CMP_DATA: if (accept) begin
                    cmp_wr_en   <= 1'b1;
                    cmp_din     <= din;
                    cmp_wr_addr <= next_addr;
                    if (next_addr == last_addr) begin
                        new_cmp_config <= 1'b1;
                        full           <= 1'b1;
                        state          <= ST_WAIT_APPLIED;
                    end
                end
                ST_WAIT_APPLIED: if (cmp_config_applied) begin
                    new_cmp_config <= 1'b0;
                    full           <= 1'b0;
                    subtype        <= pending_sub;
                    state          <= ST_MAGIC;
                end
                ST_MAGIC: if (accept) begin
                    if (din == MAGIC) begin
                        state <= ST_SALT;
                    end else begin
                        error <= 1'b1;
                        full  <= 1'b1;
                        state <= ST_ERROR;
                    end
                end
                ST_ERROR: if (error_clr) begin
                    error    <= 1'b0;
                    full     <= 1'b0;
                    byte_cnt <= '0;
                    state    <= ST_SALT;
                end
                default: state <= ST_SALT;
            endcase
        end
    end

    cmp_config_ram #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_ram (
        .CLK   (CLK),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (addr),
        .rdata (dout)
    );

endmodule

// File: tb/tb_cmp_config_rx.sv
// -----------------------------------------------------------------------------
// tb_cmp_config_rx
// Directed bench for cmp_config_rx. Two instances: u_dut1 with default
// parameters and u_dut2 with SALT_BYTES=8, ITER_BYTES=1, CMP_WORD_BYTES=2.
// Comparator writes are checked by a monitor per instance against a queue of
// expected (address, data) pairs pushed by the stimulus.
// -----------------------------------------------------------------------------
module tb_cmp_config_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // instance 1: default parameters
    logic [7:0]  din1;
    logic        wr_en1, error_clr1, mode_cmp1, ack1;
    logic        full1, error1, new1, cmp_we1;
    logic [9:0]  hc1;
    logic [10:0] ca1;
    logic [7:0]  cd1;
    logic [2:0]  addr1;
    logic [31:0] dout1;
    logic [1:0]  sub1;

    // instance 2: small configuration
    logic [7:0]  din2;
    logic        wr_en2, error_clr2, mode_cmp2, ack2;
    logic        full2, error2, new2, cmp_we2;
    logic [9:0]  hc2;
    logic [9:0]  ca2;
    logic [7:0]  cd2;
    logic [1:0]  addr2;
    logic [31:0] dout2;
    logic [1:0]  sub2;

    cmp_config_rx u_dut1 (
        .CLK(clk), .RST_N(rst_n), .din(din1), .wr_en(wr_en1), .full(full1),
        .error(error1), .error_clr(error_clr1), .mode_cmp(mode_cmp1),
        .new_cmp_config(new1), .cmp_config_applied(ack1), .hash_count(hc1),
        .cmp_wr_addr(ca1), .cmp_wr_en(cmp_we1), .cmp_din(cd1),
        .addr(addr1), .dout(dout1), .subtype(sub1)
    );

    cmp_config_rx #(
        .SALT_BYTES(8), .ITER_BYTES(1), .CMP_WORD_BYTES(2)
    ) u_dut2 (
        .CLK(clk), .RST_N(rst_n), .din(din2), .wr_en(wr_en2), .full(full2),
        .error(error2), .error_clr(error_clr2), .mode_cmp(mode_cmp2),
        .new_cmp_config(new2), .cmp_config_applied(ack2), .hash_count(hc2),
        .cmp_wr_addr(ca2), .cmp_wr_en(cmp_we2), .cmp_din(cd2),
        .addr(addr2), .dout(dout2), .subtype(sub2)
    );

    typedef struct {
        int         addr;
        logic [7:0] data;
    } wr_t;

    wr_t q1[$];
    wr_t q2[$];
    int  total   = 0;
    int  bad     = 0;
    int  pulses1 = 0;
    int  pulses2 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin : mon1
        wr_t e;
        if (cmp_we1 === 1'b1) begin
            pulses1++;
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL cmp1_unexpected: got addr %0d data %h want no write", ca1, cd1);
            end else begin
                e = q1.pop_front();
                if (ca1 !== 11'(e.addr) || cd1 !== e.data) begin
                    bad++;
                    $display("FAIL cmp1_write: got addr %0d data %h want addr %0d data %h",
                             ca1, cd1, e.addr, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin : mon2
        wr_t e;
        if (cmp_we2 === 1'b1) begin
            pulses2++;
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL cmp2_unexpected: got addr %0d data %h want no write", ca2, cd2);
            end else begin
                e = q2.pop_front();
                if (ca2 !== 10'(e.addr) || cd2 !== e.data) begin
                    bad++;
                    $display("FAIL cmp2_write: got addr %0d data %h want addr %0d data %h",
                             ca2, cd2, e.addr, e.data);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send1(input logic [7:0] b);
        din1 = b; wr_en1 = 1'b1;
        @(posedge clk); #1;
        wr_en1 = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        din2 = b; wr_en2 = 1'b1;
        @(posedge clk); #1;
        wr_en2 = 1'b0;
    endtask

    task automatic salt1(input logic [7:0] base);
        for (int i = 0; i < 16; i++) send1(8'(base + i));
    endtask

    task automatic tail1(input logic [7:0] st, input logic [31:0] iter,
                         input logic [15:0] cnt, input logic mode);
        mode_cmp1 = mode;
        send1(st);
        for (int i = 0; i < 4; i++) send1(iter[8*i +: 8]);
        send1(cnt[7:0]);
        send1(cnt[15:8]);
    endtask

    task automatic cmp1(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            q1.push_back('{addr: i, data: 8'(base + i)});
            send1(8'(base + i));
        end
    endtask

    task automatic ack1_now();
        ack1 = 1'b1;
        @(posedge clk); #1;
        ack1 = 1'b0;
    endtask

    task automatic read1(input string name, input logic [2:0] a, input logic [31:0] exp);
        addr1 = a; #1;
        check(name, dout1, exp);
    endtask

    task automatic read2(input string name, input logic [1:0] a, input logic [31:0] exp);
        addr2 = a; #1;
        check(name, dout2, exp);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        din1 = '0; wr_en1 = 0; error_clr1 = 0; mode_cmp1 = 1; ack1 = 0; addr1 = '0;
        din2 = '0; wr_en2 = 0; error_clr2 = 0; mode_cmp2 = 1; ack2 = 0; addr2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_full", full1, 0);
        check("rst_error", error1, 0);
        check("rst_new", new1, 0);
        check("rst_cmp_we", cmp_we1, 0);
        check("rst_subtype", sub1, 0);
        check("rst_cmp_addr", ca1, 32'h7FF);
        check("rst_hash_count", hc1, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // --- packet 1: mode_cmp=1, 'b', iter 0x20, count 2, ack after 5 cycles
        pulses1 = 0;
        salt1(8'h00);
        tail1("b", 32'h20, 16'd2, 1'b1);
        check("p1_hash_count", hc1, 2);
        cmp1(8, 8'hA0);
        check("p1_full_up", full1, 1);
        check("p1_new_up", new1, 1);
        repeat (5) @(posedge clk);
        #1;
        check("p1_full_hold", full1, 1);
        ack1_now();
        check("p1_full_drop", full1, 0);
        check("p1_new_drop", new1, 0);
        check("p1_subtype", sub1, 1);
        read1("p1_dout1", 3'd1, 32'h03020100);
        read1("p1_dout0", 3'd0, 32'h00000020);
        read1("p1_dout4", 3'd4, 32'h0F0E0D0C);
        read1("p1_dout5", 3'd5, 32'h0);
        read1("p1_dout7", 3'd7, 32'h0);
        send1(8'hCC);
        check("p1_error", error1, 0);
        check("p1_pulses", pulses1, 8);
        check("p1_queue_empty", q1.size(), 0);

        // --- packet 2: mode_cmp=0, count 0, 'x', immediate ack
        salt1(8'h40);
        tail1("x", 32'h5, 16'd0, 1'b0);
        check("p2_full_up", full1, 1);
        check("p2_hash_count", hc1, 0);
        ack1_now();
        check("p2_full_drop", full1, 0);
        check("p2_subtype", sub1, 2);
        check("p2_pulses", pulses1, 8);
        send1(8'hCC);

        // --- packet 3: accepted after magic; count NUM_HASHES+1 is an error
        for (int i = 0; i < 4; i++) send1(8'(8'h11 + i));
        @(posedge clk); #1;
        read1("p3_salt_written", 3'd1, 32'h14131211);
        for (int i = 4; i < 16; i++) send1(8'(8'h11 + i));
        mode_cmp1 = 1'b1;
        send1("a");
        for (int i = 0; i < 4; i++) send1(8'h00);
        send1(8'h01);
        check("p3_no_error_before", error1, 0);
        send1(8'h02);
        check("p3_error", error1, 1);
        check("p3_full", full1, 1);
        error_clr1 = 1'b1; din1 = 8'h55; wr_en1 = 1'b1;
        @(posedge clk); #1;
        error_clr1 = 1'b0; wr_en1 = 1'b0;
        check("p3_clr_error", error1, 0);
        check("p3_clr_full", full1, 0);

        // --- packet 4: valid after clear, 'y', count 1, immediate ack
        salt1(8'h30);
        tail1("y", 32'h100, 16'd1, 1'b1);
        cmp1(4, 8'hB0);
        check("p4_full_up", full1, 1);
        ack1_now();
        check("p4_full_drop", full1, 0);
        check("p4_subtype", sub1, 3);
        read1("p4_dout1", 3'd1, 32'h33323130);
        read1("p4_dout0", 3'd0, 32'h00000100);
        send1(8'hCC);
        check("p4_error", error1, 0);

        // --- packet 5: bad subtype 'z', then wr_en held high
        salt1(8'h50);
        send1("z");
        check("p5_error", error1, 1);
        check("p5_full", full1, 1);
        din1 = 8'hCC; wr_en1 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        wr_en1 = 1'b0;
        check("p5_error_hold", error1, 1);
        check("p5_full_hold", full1, 1);
        check("p5_new_hold", new1, 0);
        check("p5_subtype_hold", sub1, 3);
        read1("p5_salt_kept", 3'd1, 32'h53525150);
        error_clr1 = 1'b1;
        @(posedge clk); #1;
        error_clr1 = 1'b0;
        check("p5_clr", error1, 0);

        // --- packet 6: wrong magic byte
        salt1(8'h60);
        tail1("a", 32'h1, 16'd0, 1'b0);
        ack1_now();
        check("p6_subtype", sub1, 0);
        send1(8'h00);
        check("p6_magic_error", error1, 1);
        error_clr1 = 1'b1;
        @(posedge clk); #1;
        error_clr1 = 1'b0;

        // --- packet 7: reset in the middle of CMP_DATA
        salt1(8'h70);
        tail1("y", 32'h3, 16'd2, 1'b1);
        cmp1(3, 8'hC0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("r_full", full1, 0);
        check("r_error", error1, 0);
        check("r_new", new1, 0);
        check("r_cmp_we", cmp_we1, 0);
        check("r_subtype", sub1, 0);
        check("r_cmp_addr", ca1, 32'h7FF);
        check("r_hash_count", hc1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        salt1(8'h80);
        tail1("b", 32'h77, 16'd1, 1'b1);
        cmp1(4, 8'hD0);
        check("p7_full_up", full1, 1);
        ack1_now();
        check("p7_subtype", sub1, 1);
        check("p7_hash_count", hc1, 1);
        read1("p7_dout0", 3'd0, 32'h00000077);
        read1("p7_dout4", 3'd4, 32'h8F8E8D8C);
        send1(8'hCC);
        check("p7_error", error1, 0);
        check("p7_queue_empty", q1.size(), 0);

        // --- instance 2: 8 salt bytes, 1 iter byte, 2 cmp bytes/hash, count 3
        pulses2 = 0;
        for (int i = 0; i < 8; i++) send2(8'(8'h20 + i));
        send2("a");
        send2(8'h07);
        send2(8'h03);
        send2(8'h00);
        check("d2_hash_count", hc2, 3);
        for (int i = 0; i < 6; i++) begin
            q2.push_back('{addr: i, data: 8'(8'hE0 + i)});
            send2(8'(8'hE0 + i));
        end
        check("d2_full_up", full2, 1);
        ack2 = 1'b1;
        @(posedge clk); #1;
        ack2 = 1'b0;
        check("d2_full_drop", full2, 0);
        read2("d2_dout1", 2'd1, 32'h23222120);
        read2("d2_dout2", 2'd2, 32'h27262524);
        read2("d2_dout0", 2'd0, 32'h00000007);
        read2("d2_dout3", 2'd3, 32'h0);
        send2(8'hCC);
        check("d2_error", error2, 0);
        check("d2_pulses", pulses2, 6);
        check("d2_queue_empty", q2.size(), 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
